// File: rtl/quad_encoder_gen_if.sv
// Command/status bundle for quad_encoder_gen.
// Optional index output is present when QUAD_GEN_INDEX_EN is defined.
interface quad_encoder_gen_if #(
  parameter int unsigned PERIOD_W = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [31:0]         cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;
  logic                abort;
  logic                quadA;
  logic                quadB;
`ifdef QUAD_GEN_INDEX_EN
  logic                quadZ;
`endif
  logic [31:0]         position;
  logic                busy;
  logic                done;

`ifdef QUAD_GEN_INDEX_EN
  modport master (
    output cmd_valid, cmd_steps, cmd_period, abort,
    input  cmd_ready, quadA, quadB, quadZ, position, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_steps, cmd_period, abort,
    output cmd_ready, quadA, quadB, quadZ, position, busy, done
  );
`else
  modport master (
    output cmd_valid, cmd_steps, cmd_period, abort,
    input  cmd_ready, quadA, quadB, position, busy, done
  );
  modport slave (
    input  cmd_valid, cmd_steps, cmd_period, abort,
    output cmd_ready, quadA, quadB, position, busy, done
  );
`endif
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature signal generator: turns signed step commands into A/B edges
// spaced a programmable number of clocks apart. Each edge is one count, and
// A/B are derived from position[1:0] so direction changes are glitch-free.
// Optional index output (quadZ, high while the index counter is 0) is built
// when QUAD_GEN_INDEX_EN is defined.
module quad_encoder_gen #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned CPR      = 2048
) (
  input  logic            clk,
  input  logic            rst,
  quad_encoder_gen_if.slave bus
);

  localparam int unsigned IDX_W = (CPR > 1) ? $clog2(CPR) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Elaboration guard: index counter needs at least one full A/B cycle.
  if (CPR < 4) begin : g_cpr_check
    $error("quad_encoder_gen: CPR must be >= 4");
  end

  state_t              r_state;
  logic                r_dir;        // 1 = counting down
  logic [31:0]         r_remaining;
  logic [PERIOD_W-1:0] r_per;
  logic [PERIOD_W-1:0] r_timer;
  logic [31:0]         r_pos;
  logic                r_a;
  logic                r_b;
  logic                r_busy;
  logic                r_done;
  logic                r_ready;
`ifdef QUAD_GEN_INDEX_EN
  logic [IDX_W-1:0]    r_idx;
  logic                r_z;
  logic [IDX_W-1:0]    w_idx_next;
`endif

  logic [31:0]         w_steps_u;
  logic [31:0]         w_abs;
  logic [PERIOD_W-1:0] w_per;
  logic [31:0]         w_pos_next;

  // Command decode: magnitude, direction and clamped period.
  always_comb begin
    w_steps_u = bus.cmd_steps;
    w_abs     = w_steps_u[31] ? (~w_steps_u + 32'd1) : w_steps_u;
    w_per     = (bus.cmd_period == '0) ? PERIOD_W'(1) : bus.cmd_period;
    w_pos_next = r_dir ? (r_pos - 32'd1) : (r_pos + 32'd1);
  end

`ifdef QUAD_GEN_INDEX_EN
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(CPR - 1);

  // Index counter next value, wrapping at 0 and CPR-1.
  always_comb begin
    w_idx_next = r_idx;
    if (r_dir) begin
      w_idx_next = (r_idx == '0) ? IDX_MAX : (r_idx - IDX_W'(1));
    end else begin
      w_idx_next = (r_idx == IDX_MAX) ? '0 : (r_idx + IDX_W'(1));
    end
  end
`endif

  // Control FSM with registered outputs; edges are emitted in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_per       <= PERIOD_W'(1);
      r_timer     <= '0;
      r_pos       <= '0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
`ifdef QUAD_GEN_INDEX_EN
      r_idx       <= '0;
      r_z         <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.cmd_valid) begin
            r_dir       <= w_steps_u[31];
            r_remaining <= w_abs;
            r_per       <= w_per;
            r_timer     <= w_per - PERIOD_W'(1);
            r_ready     <= 1'b0;
            if (w_abs == 32'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (bus.abort) begin
            // Abort wins over an edge due in the same cycle.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_timer == '0) begin
            r_pos       <= w_pos_next;
            r_a         <= w_pos_next[1] ^ w_pos_next[0];
            r_b         <= w_pos_next[1];
`ifdef QUAD_GEN_INDEX_EN
            r_idx       <= w_idx_next;
            r_z         <= (w_idx_next == '0);
`endif
            r_remaining <= r_remaining - 32'd1;
            r_timer     <= r_per - PERIOD_W'(1);
            if (r_remaining == 32'd1) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - PERIOD_W'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = r_ready;
  assign bus.quadA     = r_a;
  assign bus.quadB     = r_b;
  assign bus.position  = r_pos;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
`ifdef QUAD_GEN_INDEX_EN
  assign bus.quadZ     = r_z;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen (index checks when QUAD_GEN_INDEX_EN).
module tb_quad_encoder_gen;

  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned CPR      = 4;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] ab_tbl [4];

  quad_encoder_gen_if #(.PERIOD_W(PERIOD_W)) bus ();

  quad_encoder_gen #(.PERIOD_W(PERIOD_W), .CPR(CPR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Checks every output against the expected position and status flags.
  task automatic check_out(input string tag, input int pos, input bit e_busy,
                           input bit e_done, input bit e_ready);
    logic [1:0] ab;
    ab = ab_tbl[pos % 4];
    check({tag, ".position"}, bus.position, 32'(pos));
    check({tag, ".quadA"}, 32'(bus.quadA), 32'(ab[1]));
    check({tag, ".quadB"}, 32'(bus.quadB), 32'(ab[0]));
    check({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
    check({tag, ".done"}, 32'(bus.done), 32'(e_done));
    check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'(e_ready));
`ifdef QUAD_GEN_INDEX_EN
    check({tag, ".quadZ"}, 32'(bus.quadZ), 32'((pos % 4) == 0));
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offers a command for one clock; returns at the negedge after the accept edge.
  task automatic send(input int steps, input int per);
    @(negedge clk);
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = 32'(steps);
    bus.cmd_period = PERIOD_W'(per);
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
  endtask

  initial begin
    ab_tbl[0] = 2'b00;
    ab_tbl[1] = 2'b10;
    ab_tbl[2] = 2'b11;
    ab_tbl[3] = 2'b01;

    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_period = '0;
    bus.abort      = 1'b0;
    tick(2);
    check_out("reset", 0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    tick(1);
    check_out("post_reset", 0, 1'b0, 1'b0, 1'b1);

    // +8 steps, period 4: edges at T+4..T+32.
    send(8, 4);
    check_out("up.accept", 0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick(3);
      check_out($sformatf("up.pre%0d", k), k - 1, 1'b1, 1'b0, 1'b0);
      tick(1);
      if (k < 8) check_out($sformatf("up.edge%0d", k), k, 1'b1, 1'b0, 1'b0);
      else       check_out("up.done", 8, 1'b0, 1'b1, 1'b0);
    end
    tick(1);
    check_out("up.ready", 8, 1'b0, 1'b0, 1'b1);

    // -5 steps, period 1: one edge per clock down to 3.
    send(-5, 1);
    check_out("dn.accept", 8, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (k < 5) check_out($sformatf("dn.edge%0d", k), 8 - k, 1'b1, 1'b0, 1'b0);
      else       check_out("dn.done", 3, 1'b0, 1'b1, 1'b0);
    end
    tick(1);
    check_out("dn.ready", 3, 1'b0, 1'b0, 1'b1);

    // Zero steps: straight to done, no busy, no edge.
    send(0, 7);
    check_out("zero.done", 3, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_out("zero.ready", 3, 1'b0, 1'b0, 1'b1);

    // Period 0 behaves as period 1.
    send(1, 0);
    check_out("p0.accept", 3, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("p0.done", 4, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_out("p0.ready", 4, 1'b0, 1'b0, 1'b1);

    // 100 steps, period 10, abort on the cycle the 4th edge is due.
    send(100, 10);
    tick(30);
    check_out("abort.3edges", 7, 1'b1, 1'b0, 1'b0);
    tick(9);
    check_out("abort.pre", 7, 1'b1, 1'b0, 1'b0);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check_out("abort.done", 7, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_out("abort.ready", 7, 1'b0, 1'b0, 1'b1);
    bus.abort = 1'b1;
    tick(2);
    bus.abort = 1'b0;
    check_out("abort.idle_ignored", 7, 1'b0, 1'b0, 1'b1);

    // Async reset mid-RUN: outputs clear without a clock edge.
    send(50, 2);
    tick(6);
    check_out("rst.run", 10, 1'b1, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_out("rst.async", 0, 1'b0, 1'b0, 1'b1);
    tick(3);
    rst = 1'b0;
    tick(4);
    check_out("rst.quiet", 0, 1'b0, 1'b0, 1'b1);

    send(3, 1);
    tick(1);
    check_out("post_rst.e1", 1, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("post_rst.e2", 2, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_out("post_rst.done", 3, 1'b0, 1'b1, 1'b0);
    tick(1);
    check_out("post_rst.ready", 3, 1'b0, 1'b0, 1'b1);

    // Down through zero: position wraps to 0xFFFFFFFF.
    send(-4, 1);
    tick(3);
    check_out("wrap.zero", 0, 1'b1, 1'b0, 1'b0);
    tick(1);
    check("wrap.position", bus.position, 32'hFFFF_FFFF);
    check("wrap.quadA", 32'(bus.quadA), 32'd0);
    check("wrap.quadB", 32'(bus.quadB), 32'd1);
    check("wrap.done", 32'(bus.done), 32'd1);
`ifdef QUAD_GEN_INDEX_EN
    check("wrap.quadZ", 32'(bus.quadZ), 32'd0);
`endif
    tick(1);
    check("wrap.ready", 32'(bus.cmd_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
